// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin burst arbiter with a registered output stage.
// Ports: clk, rst, in0/in1 valid/data/last/ready, out valid/data/sel/ready, busy.
module mux2_rr_arbiter #(
  parameter int DATA_WIDTH = 3,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in0_valid,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic                  in0_last,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_last,
  output logic                  in1_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sel,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT =
    CNT_WIDTH'(MAX_BURST - 1);

  state_t                 state;
  logic                   prio;
  logic [CNT_WIDTH-1:0]   cnt;

  logic                   slot_free;
  logic                   acc;
  logic [DATA_WIDTH-1:0]  acc_data;
  logic                   acc_last;
  logic                   rel;

  // The output register can take a new beat when empty or draining.
  assign slot_free = !out_valid || out_ready;
  assign in0_ready = (state == GRANT0) && slot_free;
  assign in1_ready = (state == GRANT1) && slot_free;

  assign acc = (in0_valid && in0_ready) ||
               (in1_valid && in1_ready);
  assign acc_data = (state == GRANT1) ? in1_data : in0_data;
  assign acc_last = (state == GRANT1) ? in1_last : in0_last;

  // Release on last, or when this beat fills the burst quota.
  assign rel = acc && (acc_last || cnt == LAST_CNT);

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in0_valid && (!in1_valid || !prio))
            state <= GRANT0;
          else if (in1_valid)
            state <= GRANT1;
        end
        GRANT0, GRANT1: begin
          if (rel) begin
            state <= IDLE;
            cnt   <= '0;
            prio  <= (state == GRANT0);
          end else if (acc) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= acc_data;
        out_sel   <= (state == GRANT1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter.
// Burst-level model compared every cycle, plus literal beat logs.
module tb_mux2_rr_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in0_valid = 1'b0;
  logic [2:0] in0_data = '0;
  logic       in0_last = 1'b0;
  logic       in1_valid = 1'b0;
  logic [2:0] in1_data = '0;
  logic       in1_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       in0_ready, in1_ready;
  logic       out_valid, out_sel, busy;
  logic [2:0] out_data;

  mux2_rr_arbiter #(
    .DATA_WIDTH(3), .MAX_BURST(MB), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data),
    .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data),
    .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  bit rnd = 0;

  // Source queues: {last, data}
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  // Delivered beats: {sel, data}
  logic [3:0] mlog[$];
  logic [3:0] exp_q[$];

  // Model: owner -1 means nobody holds a grant
  int   m_own = -1;
  int   m_beats = 0;
  int   m_prio = 0;
  bit   m_ov = 0;
  bit   m_os = 0;
  logic [2:0] m_od = '0;

  always @(posedge clk) begin : model
    bit r0, r1, a;
    bit l;
    logic [2:0] d;
    if (rst) begin
      m_own = -1; m_beats = 0; m_prio = 0;
      m_ov = 0; m_os = 0; m_od = '0;
    end else begin
      if (m_ov && out_ready) mlog.push_back({m_os, m_od});
      r0 = (m_own == 0) && (!m_ov || out_ready);
      r1 = (m_own == 1) && (!m_ov || out_ready);
      a = (r0 && in0_valid) || (r1 && in1_valid);
      if (m_own < 0) begin
        if (in0_valid && in1_valid) m_own = m_prio;
        else if (in0_valid) m_own = 0;
        else if (in1_valid) m_own = 1;
      end else if (a) begin
        d = (m_own == 1) ? in1_data : in0_data;
        l = (m_own == 1) ? in1_last : in0_last;
        m_beats++;
        m_ov = 1; m_od = d; m_os = (m_own == 1);
        if (l || m_beats == MB) begin
          m_prio = 1 - m_own;
          m_own = -1;
          m_beats = 0;
        end
      end
      if (!a && out_ready) m_ov = 0;
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] got, exp;
    bit e0, e1;
    if (started) begin
      e0 = (m_own == 0) && (!m_ov || out_ready);
      e1 = (m_own == 1) && (!m_ov || out_ready);
      got = {in0_ready, in1_ready, out_valid, out_sel,
             out_data, busy};
      exp = {e0, e1, m_ov, m_os, m_od, m_own >= 0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle t=%0t got=%b exp=%b", $time, got, exp);
      end
    end
  end

  // Source driver: pops on handshake, presents queue heads.
  initial begin : driver
    bit a0, a1;
    forever begin
      @(negedge clk);
      a0 = in0_valid && in0_ready;
      a1 = in1_valid && in1_ready;
      @(posedge clk);
      #1;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      if (rnd) begin
        in0_valid = 1'($urandom); in0_data = 3'($urandom);
        in0_last = 1'($urandom);
        in1_valid = 1'($urandom); in1_data = 3'($urandom);
        in1_last = 1'($urandom);
      end else begin
        in0_valid = q0.size() > 0;
        in1_valid = q1.size() > 0;
        if (q0.size() > 0) {in0_last, in0_data} = q0[0];
        if (q1.size() > 0) {in1_last, in1_data} = q1[0];
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_log(string name);
    chk({name, "_len"}, mlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mlog.size(); i++)
      chk($sformatf("%s_%0d", name, i), mlog[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    tick();
    rst = 1'b0;
    mlog.delete();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && m_own < 0 &&
             !m_ov && !in0_valid && !in1_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=busy exp=idle", name);
    end
  endtask

  initial begin
    // 1: reset with random inputs
    rst = 1'b1;
    rnd = 1;
    tick();
    started = 1;
    repeat (2) begin
      out_ready = 1'($urandom);
      tick();
    end
    rnd = 0;
    out_ready = 1'b1;
    tick();
    chk("reset_rdy", {in0_ready, in1_ready}, 0);
    chk("reset_out", {out_valid, out_sel, out_data}, 0);
    rst = 1'b0;
    tick();

    // 2: in0 only, 3 beats
    q0.push_back({1'b0, 3'd5});
    q0.push_back({1'b0, 3'd6});
    q0.push_back({1'b1, 3'd7});
    wait_done("t2");
    exp_q = '{4'h5, 4'h6, 4'h7};
    chk_log("t2");

    // 3: alternating single-beat bursts
    do_reset();
    q0.push_back({1'b1, 3'd1});
    q0.push_back({1'b1, 3'd2});
    q1.push_back({1'b1, 3'd3});
    q1.push_back({1'b1, 3'd4});
    wait_done("t3");
    exp_q = '{4'h1, 4'hB, 4'h2, 4'hC};
    chk_log("t3");

    // 4: forced release after MAX_BURST beats
    do_reset();
    for (int i = 1; i <= 6; i++)
      q1.push_back({i == 6, 3'(i)});
    tick(2);
    q0.push_back({1'b1, 3'd7});
    wait_done("t4");
    exp_q = '{4'h9, 4'hA, 4'hB, 4'hC, 4'h7, 4'hD, 4'hE};
    chk_log("t4");

    // 5: downstream stall
    do_reset();
    for (int i = 1; i <= 4; i++)
      q0.push_back({i == 4, 3'(i)});
    tick(4);
    out_ready = 1'b0;
    tick(3);
    chk("t5_stall_rdy", in0_ready, 0);
    chk("t5_stall_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_done("t5");
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4};
    chk_log("t5");

    // 6: reset mid-burst, then clean restart with prio=0
    do_reset();
    for (int i = 1; i <= 4; i++)
      q0.push_back({i == 4, 3'(i)});
    begin
      int n = 0;
      while (mlog.size() < 1 && n < 50) begin
        tick();
        n++;
      end
      chk("t6_first_beat", mlog.size(), 1);
    end
    do_reset();
    chk("t6_idle_rdy", in0_ready, 0);
    q0.push_back({1'b1, 3'd5});
    q1.push_back({1'b1, 3'd6});
    wait_done("t6");
    exp_q = '{4'h5, 4'hE};
    chk_log("t6");

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
